dmem_responder: RTL

- Memory-side responder for the core's data port. Receives writeFlag/memoryRead/addressIn/dataOut from the core and returns memoryDataIn.
- Word-organised synchronous RAM with a programmable wait-state count, a one-cycle memoryReady completion pulse and a busy indication.
- Sits beside the core at top level and replaces the zero-latency behavioural data array.

---
 rtl/dmem_responder_pkg.sv | 22 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, op codes,
// the poisoned read value and the access-check helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam logic        OP_RD         = 1'b0;
    localparam logic        OP_WR         = 1'b1;
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

    // Misaligned byte address, or address bits beyond the array's reach.
    function automatic logic dmem_addr_bad(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] upper_s;
        upper_s = addr >> (addr_w + 32'd2);
        return (addr[1:0] != 2'b00) || (upper_s != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with registered read data; kept separate so it can be
// replaced by a vendor macro without touching the responder control.
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [31:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    // Read register only moves on a read, so it holds the last read word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for the core's data port.
// Optional access checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memoryRead,
    input  logic        writeFlag,
    input  logic [31:0] addressIn,
    input  logic [31:0] dataOut,
    output logic [31:0] memoryDataIn,
    output logic        memoryReady,
    output logic        memoryBusy,
    output logic        memErr
);

`ifdef DMEM_ERR_CHECK_EN
    localparam logic ERR_CHECK = 1'b1;
`else
    localparam logic ERR_CHECK = 1'b0;
`endif

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              bad_q, bad_d;
    logic              rd_bad_q, rd_bad_d;
    logic              access_bad_s;
    logic              ram_we_s, ram_re_s;
    logic [31:0]       ram_rdata_s;

    assign access_bad_s = ERR_CHECK & dmem_addr_bad(addressIn, ADDR_W);

    // Next-state, request capture and completion strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        bad_d    = bad_q;
        case (state_q)
            DMEM_IDLE: begin
                if (memoryRead ^ writeFlag) begin
                    op_d    = writeFlag ? OP_WR : OP_RD;
                    idx_d   = addressIn[ADDR_W+1:2];
                    wdata_d = dataOut;
                    cnt_d   = LAT_M1;
                    bad_d   = access_bad_s;
                    err_d   = err_q | access_bad_s;
                    state_d = (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
                end else if (memoryRead & writeFlag) begin
                    err_d = err_q | ERR_CHECK;
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DMEM_RESP: begin
                state_d = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase

        ready_d  = (state_d == DMEM_RESP);
        busy_d   = (state_d == DMEM_WAIT);
        // The array is touched on the edge that closes RESP, so a reset
        // anywhere before then aborts the operation cleanly.
        ram_we_s = (state_q == DMEM_RESP) && (op_q == OP_WR) && !bad_q;
        ram_re_s = (state_q == DMEM_RESP) && (op_q == OP_RD);
        rd_bad_d = ram_re_s ? bad_q : rd_bad_q;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= 4'd0;
            op_q     <= OP_RD;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
            rd_bad_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            bad_q    <= bad_d;
            rd_bad_q <= rd_bad_d;
        end
    end

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .rst_n (rst),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata_s)
    );

    assign memoryDataIn = rd_bad_q ? DMEM_ERR_DATA : ram_rdata_s;
    assign memoryReady  = ready_q;
    assign memoryBusy   = busy_q;
    assign memErr       = err_q;

endmodule
